// File: rtl/axi_regs_pkg.sv
// Shared definitions for the AXI burst register bridge: burst and response
// encodings, FSM state types and the burst index stepping function.
package axi_regs_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        W_ADDR,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic [1:0] {
        R_ADDR,
        R_ISSUE,
        R_WAIT,
        R_DATA
    } rstate_t;

    // Window mask for a WRAP burst: len+1 beats rounded up to a power of two, minus one.
    function automatic logic [3:0] wrap_mask(input logic [3:0] len);
        return len | (len >> 1) | (len >> 2) | (len >> 3);
    endfunction

    // Register index of the next beat. Reserved burst type 3 behaves as INCR.
    function automatic logic [15:0] next_index(input logic [15:0] index,
                                               input logic [1:0]  burst,
                                               input logic [3:0]  len);
        logic [15:0] mask;
        mask = {12'd0, wrap_mask(len)};
        case (burst)
            BURST_FIXED: return index;
            BURST_WRAP:  return (index & ~mask) | ((index + 16'd1) & mask);
            default:     return index + 16'd1;
        endcase
    endfunction

endpackage

// File: rtl/axi_burst_registers_if.sv
// AXI3 bus bundle (32-bit data, 4-bit burst length) with master and slave views.
interface axi_ifc #(
    parameter int ID_WIDTH = 12
);
    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [ID_WIDTH-1:0] wid;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_WIDTH-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_regs_burst_addr.sv
// Per-channel burst tracker: current register index, beat counter and a flag
// that marks the final beat. Loaded when an address is accepted, stepped per beat.
module axi_regs_burst_addr
    import axi_regs_pkg::*;
#(
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [IW-1:0] start,
    input  logic [3:0]    len,
    input  logic [1:0]    burst,
    input  logic          step,
    output logic [IW-1:0] index,
    output logic          last
);

    logic [3:0] count;
    logic [3:0] len_q;
    logic [1:0] burst_q;

    // Capture the burst on load, otherwise advance index and beat count on each step.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            index   <= '0;
            count   <= '0;
            len_q   <= '0;
            burst_q <= BURST_FIXED;
            last    <= 1'b0;
        end else if (load) begin
            index   <= start;
            count   <= '0;
            len_q   <= len;
            burst_q <= burst;
            last    <= (len == 4'd0);
        end else if (step) begin
            index   <= IW'(next_index(16'(index), burst_q, len_q));
            count   <= count + 4'd1;
            last    <= ((count + 4'd1) == len_q);
        end
    end

endmodule

// File: rtl/axi_burst_registers.sv
// AXI3 slave to register-file bridge with FIXED/INCR/WRAP bursts of up to 16
// beats, byte strobes and a configurable register-file read latency.
// Define AXI_REGS_RANGE_CHECK_EN to suppress accesses at or beyond REG_COUNT
// and answer them with SLVERR; without it every beat reaches the register file.
module axi_burst_registers
    import axi_regs_pkg::*;
#(
    parameter int R_ADDR_WIDTH = 4,
    parameter int REG_COUNT    = 16,
    parameter int RD_LATENCY   = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    axi_ifc.slave                   s,
    output logic [R_ADDR_WIDTH-1:0] o_rreg,
    output logic                    o_rd,
    input  logic [31:0]             i_rdata,
    output logic [R_ADDR_WIDTH-1:0] o_wreg,
    output logic [31:0]             o_wdata,
    output logic [3:0]              o_wstrb,
    output logic                    o_wr
);

`ifdef AXI_REGS_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    localparam int IW = R_ADDR_WIDTH;

    wstate_t       wstate;
    wstate_t       wnext;
    logic [IW-1:0] w_index;
    logic          w_final;
    logic          w_ok;
    logic          w_err;
    logic          aw_hs;
    logic          w_beat;
    logic          b_hs;

    rstate_t       rstate;
    rstate_t       rnext;
    logic [IW-1:0] r_index;
    logic          r_final;
    logic          r_ok;
    logic          ar_hs;
    logic          r_hs;
    logic [2:0]    wait_cnt;
    logic          wait_done;

    logic          unused_bits;

    assign unused_bits = ^{s.awaddr[31:IW+2], s.awaddr[1:0], s.araddr[31:IW+2],
                           s.araddr[1:0], s.awsize, s.arsize, s.wlast, s.wid};

    assign aw_hs  = (wstate == W_ADDR) && s.awvalid && s.awready;
    assign w_beat = (wstate == W_DATA) && s.wvalid && s.wready;
    assign b_hs   = (wstate == W_RESP) && s.bvalid && s.bready;
    assign w_ok   = !RANGE_CHECK || (32'(w_index) < 32'(REG_COUNT));

    assign o_wr    = w_beat && w_ok;
    assign o_wreg  = w_index;
    assign o_wdata = s.wdata;
    assign o_wstrb = s.wstrb;

    axi_regs_burst_addr #(.IW(IW)) u_waddr (
        .clk   (clk),
        .rstn  (rstn),
        .load  (aw_hs),
        .start (s.awaddr[IW+1:2]),
        .len   (s.awlen),
        .burst (s.awburst),
        .step  (w_beat),
        .index (w_index),
        .last  (w_final)
    );

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) wstate <= W_ADDR;
        else       wstate <= wnext;
    end

    // Write FSM transitions; the beat count, not wlast, ends the data phase.
    always_comb begin
        wnext = wstate;
        case (wstate)
            W_ADDR:  if (aw_hs) wnext = W_DATA;
            W_DATA:  if (w_beat && w_final) wnext = W_RESP;
            W_RESP:  if (b_hs) wnext = W_ADDR;
            default: wnext = W_ADDR;
        endcase
    end

    // Write channel handshake outputs, captured ID and the sticky range error.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s.awready <= 1'b0;
            s.wready  <= 1'b0;
            s.bvalid  <= 1'b0;
            s.bid     <= '0;
            s.bresp   <= RESP_OKAY;
            w_err     <= 1'b0;
        end else begin
            s.awready <= (wnext == W_ADDR);
            s.wready  <= (wnext == W_DATA);
            s.bvalid  <= (wnext == W_RESP);
            if (aw_hs) begin
                s.bid <= s.awid;
                w_err <= 1'b0;
            end else if (w_beat && !w_ok) begin
                w_err <= 1'b1;
            end
            if (w_beat && w_final) begin
                s.bresp <= (w_err || !w_ok) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign ar_hs     = (rstate == R_ADDR) && s.arvalid && s.arready;
    assign r_hs      = (rstate == R_DATA) && s.rvalid && s.rready;
    assign wait_done = (rstate == R_WAIT) && (wait_cnt == 3'(RD_LATENCY - 1));
    assign r_ok      = !RANGE_CHECK || (32'(r_index) < 32'(REG_COUNT));

    assign o_rd   = (rstate == R_ISSUE) && r_ok;
    assign o_rreg = r_index;

    axi_regs_burst_addr #(.IW(IW)) u_raddr (
        .clk   (clk),
        .rstn  (rstn),
        .load  (ar_hs),
        .start (s.araddr[IW+1:2]),
        .len   (s.arlen),
        .burst (s.arburst),
        .step  (r_hs && !r_final),
        .index (r_index),
        .last  (r_final)
    );

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) rstate <= R_ADDR;
        else       rstate <= rnext;
    end

    // Read FSM transitions: issue one strobe, wait out the latency, present the beat.
    always_comb begin
        rnext = rstate;
        case (rstate)
            R_ADDR:  if (ar_hs) rnext = R_ISSUE;
            R_ISSUE: rnext = R_WAIT;
            R_WAIT:  if (wait_done) rnext = R_DATA;
            R_DATA:  if (r_hs) rnext = r_final ? R_ADDR : R_ISSUE;
            default: rnext = R_ADDR;
        endcase
    end

    // Read channel outputs; beat data is frozen from capture until the handshake.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s.arready <= 1'b0;
            s.rvalid  <= 1'b0;
            s.rlast   <= 1'b0;
            s.rid     <= '0;
            s.rresp   <= RESP_OKAY;
            s.rdata   <= '0;
            wait_cnt  <= '0;
        end else begin
            s.arready <= (rnext == R_ADDR);
            s.rvalid  <= (rnext == R_DATA);
            wait_cnt  <= ((rstate == R_WAIT) && !wait_done) ? wait_cnt + 3'd1 : 3'd0;
            if (ar_hs) s.rid <= s.arid;
            if (wait_done) begin
                s.rdata <= r_ok ? i_rdata : 32'd0;
                s.rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
                s.rlast <= r_final;
            end else if (r_hs) begin
                s.rlast <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_registers.sv
// Scoreboard bench for axi_burst_registers: stimulus tasks queue the expected
// register-file strobes and AXI responses, a monitor pops and compares them.
module tb_axi_burst_registers;
    import axi_regs_pkg::*;

    localparam int AW  = 4;
    localparam int RC  = 12;
    localparam int RL  = 2;
    localparam int IDW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [AW-1:0] o_rreg;
    logic [AW-1:0] o_wreg;
    logic          o_rd;
    logic          o_wr;
    logic [31:0]   i_rdata;
    logic [31:0]   o_wdata;
    logic [3:0]    o_wstrb;

    int errors = 0;
    int checks = 0;

    logic [39:0] wr_q[$];
    logic [3:0]  rd_q[$];
    logic [5:0]  b_q[$];
    logic [38:0] r_q[$];

    logic [31:0] rd_pipe[RL];

    always #5 clk = ~clk;

    axi_ifc #(.ID_WIDTH(IDW)) bus ();

    axi_burst_registers #(
        .R_ADDR_WIDTH (AW),
        .REG_COUNT    (RC),
        .RD_LATENCY   (RL)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s       (bus.slave),
        .o_rreg  (o_rreg),
        .o_rd    (o_rd),
        .i_rdata (i_rdata),
        .o_wreg  (o_wreg),
        .o_wdata (o_wdata),
        .o_wstrb (o_wstrb),
        .o_wr    (o_wr)
    );

    // Register file model: register n reads as n*0x11, valid exactly RL cycles after o_rd.
    always @(posedge clk) begin
        rd_pipe[0] <= o_rd ? 32'(o_rreg) * 32'h11 : 32'hBAD0BAD0;
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign i_rdata = rd_pipe[RL-1];

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=event required=none", name);
    endtask

    // Monitor: every strobe or response handshake must match the head of its queue.
    always @(negedge clk) begin
        if (rstn) begin
            if (o_wr) begin
                if (wr_q.size() == 0) report_fail("wr_unexpected");
                else check_output("wr_beat", {24'd0, o_wreg, o_wdata, o_wstrb}, {24'd0, wr_q.pop_front()});
            end
            if (o_rd) begin
                if (rd_q.size() == 0) report_fail("rd_unexpected");
                else check_output("rd_index", {60'd0, o_rreg}, {60'd0, rd_q.pop_front()});
            end
            if (bus.bvalid && bus.bready) begin
                if (b_q.size() == 0) report_fail("b_unexpected");
                else check_output("b_resp", {58'd0, bus.bid, bus.bresp}, {58'd0, b_q.pop_front()});
            end
            if (bus.rvalid && bus.rready) begin
                if (r_q.size() == 0) report_fail("r_unexpected");
                else check_output("r_beat", {25'd0, bus.rid, bus.rdata, bus.rresp, bus.rlast},
                                  {25'd0, r_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [3:0] idx, input logic [31:0] data, input logic [3:0] strb);
        wr_q.push_back({idx, data, strb});
    endtask

    task automatic push_r(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp, input logic last);
        r_q.push_back({id, data, resp, last});
    endtask

    task automatic apply_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [1:0] burst, input logic [31:0] data0,
                               input logic [3:0] strb, input bit gapped);
        int n;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.awready && n < 50) begin @(negedge clk); n++; end
        if (!bus.awready) report_fail("aw_timeout");
        tick();
        bus.awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            if (gapped && b == 1) begin
                bus.wvalid = 1'b0;
                tick();
                tick();
            end
            bus.wdata = data0 + 32'(b); bus.wstrb = strb; bus.wlast = (b == int'(len)); bus.wvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!bus.wready && n < 50) begin @(negedge clk); n++; end
            if (!bus.wready) report_fail("w_timeout");
            tick();
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        @(negedge clk);
        check_output("bvalid_after_last", {63'd0, bus.bvalid}, 64'd1);
        tick();
        bus.bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
        if (!bus.bvalid) report_fail("b_timeout");
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic apply_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [1:0] burst, input bit stall);
        int n;
        logic [38:0] exp;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arvalid = 1'b1;
        bus.rready = !stall;
        n = 0;
        @(negedge clk);
        while (!bus.arready && n < 50) begin @(negedge clk); n++; end
        if (!bus.arready) report_fail("ar_timeout");
        tick();
        bus.arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            @(negedge clk);
            while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
            if (!bus.rvalid) report_fail("r_timeout");
            if (stall && b == 0) begin
                if (r_q.size() == 0) report_fail("stall_no_expectation");
                exp = (r_q.size() > 0) ? r_q[0] : 39'd0;
                for (int k = 0; k < 5; k++) begin
                    check_output("stall_hold", {23'd0, bus.rvalid, bus.rid, bus.rdata, bus.rlast, o_rd},
                                 {23'd0, 1'b1, exp[38:35], exp[34:3], exp[0], 1'b0});
                    tick();
                    if (k == 4) bus.rready = 1'b1;
                    @(negedge clk);
                end
            end
            tick();
        end
        bus.rready = 1'b0;
    endtask

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = BURST_INCR;
        bus.awvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
        bus.arsize = 3'd2; bus.arburst = BURST_INCR; bus.arvalid = 1'b0; bus.rready = 1'b0;
        rstn = 1'b0;
        repeat (3) tick();

        // reset state
        @(negedge clk);
        check_output("reset_flags", {56'd0, bus.awready, bus.wready, bus.bvalid, bus.arready,
                                     bus.rvalid, bus.rlast, o_rd, o_wr}, 64'd0);
        check_output("reset_regs", {44'd0, o_rreg, o_wreg, bus.bid, bus.rid, bus.bresp, bus.rresp}, 64'd0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check_output("ready_before_edge", {62'd0, bus.awready, bus.arready}, 64'd0);
        tick();
        @(negedge clk);
        check_output("ready_after_release", {62'd0, bus.awready, bus.arready}, 64'd3);
        tick();

        // single write to index 2
        push_wr(4'd2, 32'hDEADBEEF, 4'hF);
        b_q.push_back({4'd5, RESP_OKAY});
        apply_write(4'd5, 32'h08, 4'd0, BURST_INCR, 32'hDEADBEEF, 4'hF, 1'b0);

        // INCR read burst over indices 1..4
        for (int i = 1; i <= 4; i++) rd_q.push_back(4'(i));
        push_r(4'd3, 32'h11, RESP_OKAY, 1'b0);
        push_r(4'd3, 32'h22, RESP_OKAY, 1'b0);
        push_r(4'd3, 32'h33, RESP_OKAY, 1'b0);
        push_r(4'd3, 32'h44, RESP_OKAY, 1'b1);
        apply_read(4'd3, 32'h04, 4'd3, BURST_INCR, 1'b0);

        // WRAP write: 6,7,4,5
        push_wr(4'd6, 32'h1000, 4'h3);
        push_wr(4'd7, 32'h1001, 4'h3);
        push_wr(4'd4, 32'h1002, 4'h3);
        push_wr(4'd5, 32'h1003, 4'h3);
        b_q.push_back({4'd4, RESP_OKAY});
        apply_write(4'd4, 32'h18, 4'd3, BURST_WRAP, 32'h1000, 4'h3, 1'b0);

        // FIXED write: 3,3,3
        push_wr(4'd3, 32'h2000, 4'hC);
        push_wr(4'd3, 32'h2001, 4'hC);
        push_wr(4'd3, 32'h2002, 4'hC);
        b_q.push_back({4'd6, RESP_OKAY});
        apply_write(4'd6, 32'h0C, 4'd2, BURST_FIXED, 32'h2000, 4'hC, 1'b0);

        // gapped wvalid on an INCR write: 0,1,2
        push_wr(4'd0, 32'h3000, 4'h5);
        push_wr(4'd1, 32'h3001, 4'h5);
        push_wr(4'd2, 32'h3002, 4'h5);
        b_q.push_back({4'd8, RESP_OKAY});
        apply_write(4'd8, 32'h00, 4'd2, BURST_INCR, 32'h3000, 4'h5, 1'b1);

        // read with rready held low on the first beat
        rd_q.push_back(4'd8);
        rd_q.push_back(4'd9);
        push_r(4'd7, 32'h88, RESP_OKAY, 1'b0);
        push_r(4'd7, 32'h99, RESP_OKAY, 1'b1);
        apply_read(4'd7, 32'h20, 4'd1, BURST_INCR, 1'b1);

        // concurrent write and read bursts
        for (int i = 4; i <= 7; i++) push_wr(4'(i), 32'h4000 + 32'(i - 4), 4'hF);
        b_q.push_back({4'd9, RESP_OKAY});
        rd_q.push_back(4'd5);
        rd_q.push_back(4'd6);
        push_r(4'hA, 32'h55, RESP_OKAY, 1'b0);
        push_r(4'hA, 32'h66, RESP_OKAY, 1'b1);
        fork
            apply_write(4'd9, 32'h10, 4'd3, BURST_INCR, 32'h4000, 4'hF, 1'b0);
            apply_read(4'hA, 32'h14, 4'd1, BURST_INCR, 1'b0);
        join

        // reset in the middle of a read burst
        rd_q.push_back(4'd0);
        bus.arid = 4'd2; bus.araddr = 32'h0; bus.arlen = 4'd3; bus.arburst = BURST_INCR;
        bus.arvalid = 1'b1; bus.rready = 1'b0;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus.arready && n < 50) begin @(negedge clk); n++; end
            if (!bus.arready) report_fail("ar_timeout_reset");
            tick();
            bus.arvalid = 1'b0;
            n = 0;
            @(negedge clk);
            while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
            if (!bus.rvalid) report_fail("r_timeout_reset");
        end
        tick();
        rstn = 1'b0;
        tick();
        @(negedge clk);
        check_output("reset_mid_burst", {61'd0, bus.rvalid, o_rd, bus.arready}, 64'd0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check_output("arready_release_cycle", {63'd0, bus.arready}, 64'd0);
        tick();
        @(negedge clk);
        check_output("arready_after_release", {63'd0, bus.arready}, 64'd1);
        repeat (6) tick();

        // FIXED single read after the reset
        rd_q.push_back(4'd3);
        push_r(4'd1, 32'h33, RESP_OKAY, 1'b1);
        apply_read(4'd1, 32'h0C, 4'd0, BURST_FIXED, 1'b0);

`ifdef AXI_REGS_RANGE_CHECK_EN
        // out-of-range read of index 12
        push_r(4'd1, 32'h0, RESP_SLVERR, 1'b1);
        apply_read(4'd1, 32'h30, 4'd0, BURST_INCR, 1'b0);

        // write burst over indices 10..13, only 10 and 11 reach the register file
        push_wr(4'd10, 32'h5000, 4'hF);
        push_wr(4'd11, 32'h5001, 4'hF);
        b_q.push_back({4'd3, RESP_SLVERR});
        apply_write(4'd3, 32'h28, 4'd3, BURST_INCR, 32'h5000, 4'hF, 1'b0);
`endif

        repeat (10) tick();
        check_output("wr_q_drained", 64'(wr_q.size()), 64'd0);
        check_output("rd_q_drained", 64'(rd_q.size()), 64'd0);
        check_output("b_q_drained", 64'(b_q.size()), 64'd0);
        check_output("r_q_drained", 64'(r_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
